// File: rtl/common_pkg.sv
// Shared types and defaults for the array column output path.
// Provides the drain word type, the drain collector FSM state encoding
// and the default drain geometry constants.
package common_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } drain_col_state_e;

  localparam int unsigned DRAIN_ROWS       = 4;
  localparam int unsigned DRAIN_FIFO_DEPTH = 8;
  localparam int unsigned DRAIN_LATENCY    = 2;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO, reusable by output buffers.
// Ports:
//   clk_i, rst_i     clock, synchronous active-low reset
//   push_i, data_i   write request and word
//   pop_i            read request (ignored while empty)
//   data_o           head word, valid while !empty_o
//   full_o, empty_o  occupancy flags from the registered level
//   level_o          registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is dropped unless a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted in level
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/drain_collector.sv
// Drain collector: captures a fixed-length burst of words from the top drain
// channel of an array column and buffers them for the output writer.
// Ports:
//   clk_i, rst_i      clock, synchronous active-low reset
//   start_i           request to begin a drain burst
//   start_ready_o     idle and at least ROWS free FIFO slots
//   ch_up_i           word stream from the top drain channel (no valid bit)
//   res_valid_o       FIFO head valid
//   res_data_o        FIFO head word
//   res_ready_i       consumer accepts the head
//   res_last_o        head is the final word of its burst
//                     (only with DRAIN_COLLECTOR_LAST_EN defined)
//   busy_o            burst in progress
//   level_o           registered FIFO occupancy
// Optional feature macro: DRAIN_COLLECTOR_LAST_EN adds res_last_o and one
// extra stored bit per FIFO entry.
module drain_collector
  import common_pkg::*;
#(
  parameter int unsigned ROWS    = DRAIN_ROWS,
  parameter int unsigned DEPTH   = DRAIN_FIFO_DEPTH,
  parameter int unsigned LATENCY = DRAIN_LATENCY
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    start_ready_o,
  input  logic [DATA_W-1:0]       ch_up_i,
  output logic                    res_valid_o,
  output logic [DATA_W-1:0]       res_data_o,
  input  logic                    res_ready_i,
`ifdef DRAIN_COLLECTOR_LAST_EN
  output logic                    res_last_o,
`endif
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int unsigned LW        = $clog2(DEPTH) + 1;
  localparam int unsigned RCW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WCW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned WAIT_LOAD = (LATENCY > 1) ? (LATENCY - 2) : 0;
`ifdef DRAIN_COLLECTOR_LAST_EN
  localparam int unsigned FW = DATA_W + 1;
`else
  localparam int unsigned FW = DATA_W;
`endif

  drain_col_state_e state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RCW-1:0]   row_cnt_q, row_cnt_d;
  logic             accept_c;
  logic             push_c;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;

  // Admission reserves a whole burst of slots since the channel cannot stall
  assign start_ready_o = (state_q == IDLE) && (level_o <= LW'(DEPTH - ROWS));
  assign accept_c      = start_i && start_ready_o;
  assign busy_o        = (state_q != IDLE);
  assign res_valid_o   = !fifo_empty;

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // Next state: WAIT covers the cycles between acceptance and the first word
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    row_cnt_d  = row_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          row_cnt_d = '0;
          if (LATENCY > 1) begin
            state_d    = WAIT;
            wait_cnt_d = WCW'(WAIT_LOAD);
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = CAPTURE;
        else                  wait_cnt_d = wait_cnt_q - WCW'(1);
      end
      CAPTURE: begin
        if (row_cnt_q == RCW'(ROWS - 1)) begin
          state_d   = IDLE;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + RCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: push every CAPTURE cycle, tag the final row when enabled
  always_comb begin
    push_c = (state_q == CAPTURE);
`ifdef DRAIN_COLLECTOR_LAST_EN
    fifo_wdata = {push_c && (row_cnt_q == RCW'(ROWS - 1)), ch_up_i};
`else
    fifo_wdata = ch_up_i;
`endif
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .data_i  (fifo_wdata),
    .pop_i   (res_ready_i),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign res_data_o = fifo_rdata[DATA_W-1:0];
`ifdef DRAIN_COLLECTOR_LAST_EN
  assign res_last_o = res_valid_o && fifo_rdata[FW-1];
`endif

  // Admission should make this unreachable; the FIFO drops the word if not
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (!(push_c && fifo_full && !(res_valid_o && res_ready_i)))
        else $error("drain_collector: push to full FIFO, word dropped");
    end
  end

endmodule

// File: doc/drain_collector.md
Name: drain_collector

Overview:
- Sits at the top of each array column and consumes the `ch_up_o` word stream of the top-most drain channel.
- The channel carries no valid bit. The collector is told when a drain burst begins, waits a fixed pipeline latency, then samples exactly ROWS consecutive words.
- Captured words are buffered in a FIFO and presented to the output writer over a valid/ready handshake.
- Admission control guarantees the non-stallable channel never overflows the buffer.

Parameters:
- ROWS, 4: number of words per drain burst (PEs in the column).
- DEPTH, 8: FIFO entries. Must be >= ROWS and a power of two.
- LATENCY, 2: cycles from start acceptance to the first valid word on `ch_up_i`. Must be >= 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-low reset.
- `start_i`  in  1  request to begin a drain burst.
- `start_ready_o`  out  1  collector can accept a burst now.
- `ch_up_i`  in  $bits(data_t)  word from the top drain channel.
- `res_valid_o`  out  1  FIFO head valid.
- `res_data_o`  out  $bits(data_t)  FIFO head word.
- `res_ready_i`  in  1  consumer accepts the head.
- `busy_o`  out  1  burst in progress (state != IDLE).
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (`rst_i`=0 at a clock edge):
  - state=IDLE; FIFO emptied; counters cleared.
  - `res_valid_o`=0, `busy_o`=0, `level_o`=0, `start_ready_o`=1.
  - `res_data_o` undefined while `res_valid_o`=0.
  - Reset mid-burst discards all buffered and pending words.
- Start handshake:
  - `start_ready_o` = (state==IDLE) && (DEPTH - level >= ROWS). Combinational from registered state/level.
  - A start is accepted on a cycle t where `start_i` && `start_ready_o`.
  - `start_i` while not ready is ignored; it is not queued.
- FSM states:
  - IDLE -> WAIT on accept when LATENCY>1. Wait counter loaded with LATENCY-2.
  - IDLE -> CAPTURE on accept when LATENCY==1.
  - WAIT: decrement counter; -> CAPTURE when counter==0.
  - CAPTURE: push `ch_up_i` every cycle. Row counter runs 0..ROWS-1; -> IDLE after the push with counter==ROWS-1.
- Sampling timing:
  - Words sampled at cycles t+LATENCY .. t+LATENCY+ROWS-1.
  - Word k is the k-th arrival, so word 0 is the top PE's result.
- Back-to-back bursts: a new start may be accepted the cycle state returns to IDLE, i.e. t+LATENCY+ROWS.
- Capacity:
  - Admission reserves ROWS slots, so a push never meets a full FIFO.
  - A push to a full FIFO is a design error. Guard with an assertion and drop the word.
- FIFO:
  - First-word-fall-through: `res_valid_o` = !empty; `res_data_o` = head.
  - Pop on `res_valid_o` && `res_ready_i`.
  - Simultaneous push and pop: level unchanged, both take effect.
  - Read/write pointers wrap modulo DEPTH.
- Latency and ordering:
  - A word sampled at cycle c is visible on `res_data_o` at c+1 if the FIFO was empty.
  - Output order equals arrival order.
- `level_o` is registered and reflects the push/pop of the previous edge.
- `res_ready_i` has no effect on `start_ready_o` within the same cycle.

Optional Feature:
- Macro `DRAIN_COLLECTOR_LAST_EN`.
- Defined:
  - Adds output port `res_last_o` (1 bit), stored per FIFO entry.
  - Asserted with the word that was sampled when row counter==ROWS-1, i.e. the final word of each burst.
  - Qualified by `res_valid_o`; 0 after reset.
- Undefined: the port and the extra FIFO bit do not exist; behaviour is otherwise identical.

Decomposition:
- Add to `common_pkg`:
  - `drain_col_state_e` enum {IDLE, WAIT, CAPTURE}.
  - Default constants `DRAIN_ROWS`=4, `DRAIN_FIFO_DEPTH`=8, `DRAIN_LATENCY`=2.
  - `data_t` is already provided by the package.
- Sub-module `sync_fifo`:
  - Parameterised width/depth, synchronous active-low reset, FWFT.
  - Push/pop/full/empty/level ports.
  - Reusable by other output buffers.
- The FSM and counters live in `drain_collector`; registers use the team's existing flop macros, adapted to active-low reset.

Test Plan:
- Single burst, `res_ready_i`=1: start at cycle 10, `ch_up_i`=0x11,0x22,0x33,0x44 at cycles 12-15 (LATENCY=2) -> outputs 0x11..0x44 at cycles 13-16; `busy_o` high 11-15.
- Backpressure: `res_ready_i`=0, two bursts (0x1-0x4, 0x5-0x8) -> `level_o`=8, `start_ready_o`=0. Start pulsed then is ignored. Raise ready -> 0x1..0x8 in order; `start_ready_o` returns once level<=4.
- Admission edge: level=4 with `res_ready_i`=0 -> `start_ready_o`=1. Level=5 -> `start_ready_o`=0.
- Simultaneous push/pop: level=3 with ready=1 during capture -> level holds at 3 every cycle of the burst.
- Reset mid-CAPTURE after 2 words -> next cycle `res_valid_o`=0, `level_o`=0, `busy_o`=0, `start_ready_o`=1. Subsequent burst 0xA-0xD is output intact.
- With `DRAIN_COLLECTOR_LAST_EN`, LATENCY=1: start at cycle 5, words at cycles 6-9 -> `res_last_o`=1 only on the 4th word, 0xD. Without the macro, the bench compiles with no `res_last_o` port.
